// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the score display: seven-segment codes
// (gfedcba order, active-low), the two-digit BCD type and the conversion
// FSM state type. Also provides the digit-to-segment lookup.
// ---------------------------------------------------------------------------
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Non-decimal nibbles cannot occur from the converter; they map to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_CODE[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter for one 7-bit value (0..99 expected).
// One iteration per clock; seven iterations per conversion.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (control only)
//   start    : load din and begin a conversion
//   din      : binary value to convert
//   done     : high during the cycle whose clock edge completes the last
//              iteration; bcd is valid from the following cycle on
//   bcd      : converted tens/ones digits
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] din,
  output logic       done,
  output bcd2_t      bcd
);

  logic       run;
  logic [2:0] iter;
  logic [6:0] bin;
  logic [7:0] acc;
  logic [7:0] adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      iter <= '0;
    end else if (start) begin
      run  <= 1'b1;
      iter <= '0;
    end else if (run) begin
      iter <= iter + 3'd1;
      if (iter == 3'd6) run <= 1'b0;
    end
  end

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    adj = acc;
    if (acc[3:0] >= 4'd5) adj[3:0] = acc[3:0] + 4'd3;
    if (acc[7:4] >= 4'd5) adj[7:4] = acc[7:4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      bin <= din;
      acc <= '0;
    end else if (run) begin
      acc <= {adj[6:0], bin[6]};
      bin <= {bin[5:0], 1'b0};
    end
  end

  assign done = run && (iter == 3'd6);
  assign bcd  = bcd2_t'(acc);

endmodule

// File: rtl/score_disp_7seg.sv
// ---------------------------------------------------------------------------
// score_disp_7seg
// Drives the 4-digit seven-segment display from two binary player scores.
// Scores are saturated to 99, converted to BCD by two bin2bcd_seq engines
// and latched into shadow registers in one step so the display never tears.
// Digits are scanned with a blanking gap at the start of each slot; the dot
// marks the serving side's ones digit.
//
// Build option: define SCORE_BLINK_EN to blink a side's digits after its
// value changes; without it the display is always steady.
//
// Ports:
//   clk         : system clock (65 MHz domain)
//   rst         : asynchronous active-high reset
//   score_l/r   : left/right scores, binary
//   score_valid : one-cycle strobe sampling both scores
//   serve_side  : 0 = left serves, 1 = right serves (used live)
//   seg         : segments a..g on seg[0]..seg[6], active-low
//   an          : anodes, active-low, an[3] = leftmost digit
//   dp          : decimal point, active-low
//   busy        : conversion in progress
// ---------------------------------------------------------------------------
module score_disp_7seg
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 65000,
  parameter int BLANK_CYCLES = 650,
  parameter int BLINK_CYCLES = 16250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] score_l,
  input  logic [6:0] score_r,
  input  logic       score_valid,
  input  logic       serve_side,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  if (DIGIT_CYCLES <= BLANK_CYCLES || BLINK_CYCLES < 1) begin : g_param_check
    $error("score_disp_7seg: DIGIT_CYCLES must exceed BLANK_CYCLES and BLINK_CYCLES must be positive");
  end

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  conv_state_t state, state_next;
  logic        start;
  logic [6:0]  start_l, start_r;
  logic        pend_vld;
  logic [6:0]  pend_l, pend_r;
  logic        done_l, done_r;
  bcd2_t       bcd_l, bcd_r;
  bcd2_t       shadow_l, shadow_r;

  // Conversion control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (score_valid || pend_vld) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT:   if (done_l && done_r) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A fresh strobe in IDLE takes priority over an older pending value.
  assign start_l = score_valid ? sat99(score_l) : pend_l;
  assign start_r = score_valid ? sat99(score_r) : pend_r;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              pend_vld <= 1'b0;
    else if (score_valid && state != IDLE) pend_vld <= 1'b1;
    else if (start)                        pend_vld <= 1'b0;
  end

  // Last strobe while busy wins.
  always_ff @(posedge clk) begin
    if (score_valid && state != IDLE) begin
      pend_l <= sat99(score_l);
      pend_r <= sat99(score_r);
    end
  end

  bin2bcd_seq u_conv_l (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (start_l),
    .done  (done_l),
    .bcd   (bcd_l)
  );

  bin2bcd_seq u_conv_r (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (start_r),
    .done  (done_r),
    .bcd   (bcd_r)
  );

  // Both sides update together so a half-new score is never displayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_l <= '0;
      shadow_r <= '0;
    end else if (state == DONE) begin
      shadow_l <= bcd_l;
      shadow_r <= bcd_r;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int TMR_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  // Index 0 = right side, 1 = left side (matches digit index bit 1).
  logic [1:0]       blink_act;
  logic [1:0]       blink_ph  [2];
  logic [TMR_W-1:0] blink_tmr [2];
  logic [1:0]       changed;
  logic [1:0]       blink_blank;

  assign changed = {bcd_l != shadow_l, bcd_r != shadow_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_act <= '0;
      for (int s = 0; s < 2; s++) begin
        blink_ph[s]  <= '0;
        blink_tmr[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (state == DONE && changed[s]) begin
          blink_act[s] <= 1'b1;
          blink_ph[s]  <= '0;
          blink_tmr[s] <= '0;
        end else if (blink_act[s]) begin
          if (blink_tmr[s] == TMR_W'(BLINK_CYCLES - 1)) begin
            blink_tmr[s] <= '0;
            blink_ph[s]  <= blink_ph[s] + 2'd1;
            if (blink_ph[s] == 2'd3) blink_act[s] <= 1'b0;
          end else begin
            blink_tmr[s] <= blink_tmr[s] + TMR_W'(1);
          end
        end
      end
    end
  end

  // Four half-periods starting blanked: phases 0 and 2 are dark.
  always_comb begin
    for (int s = 0; s < 2; s++) blink_blank[s] = blink_act[s] & ~blink_ph[s][0];
  end
`endif

  // Scan counters
  logic [CNT_W-1:0] slot;
  logic [1:0]       idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      idx  <= '0;
    end else if (slot == CNT_W'(DIGIT_CYCLES - 1)) begin
      slot <= '0;
      idx  <= idx + 2'd1;
    end else begin
      slot <= slot + CNT_W'(1);
    end
  end

  logic [3:0] nib_p0;
  logic       is_tens_p0;
  logic [6:0] seg_p0;
  logic [3:0] an_p0;
  logic       dp_p0;

  always_comb begin
    nib_p0     = '0;
    is_tens_p0 = 1'b0;
    case (idx)
      2'd0: nib_p0 = shadow_r.ones;
      2'd1: begin nib_p0 = shadow_r.tens; is_tens_p0 = 1'b1; end
      2'd2: nib_p0 = shadow_l.ones;
      default: begin nib_p0 = shadow_l.tens; is_tens_p0 = 1'b1; end
    endcase

    seg_p0 = (is_tens_p0 && nib_p0 == 4'd0) ? SEG_BLANK : seg_decode(nib_p0);
`ifdef SCORE_BLINK_EN
    if (blink_blank[idx[1]]) seg_p0 = SEG_BLANK;
`endif
    an_p0 = ~(4'b0001 << idx);
    dp_p0 = ~(idx == (serve_side ? 2'd0 : 2'd2));

    // Anti-ghosting gap at the start of every slot.
    if (slot < CNT_W'(BLANK_CYCLES)) begin
      an_p0  = 4'hF;
      seg_p0 = SEG_BLANK;
      dp_p0  = 1'b1;
    end
  end

  // Registered pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'hF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: doc/score_disp_7seg.md
Name: score_disp_7seg

Overview:
Drives the Basys3 4-digit seven-segment display from the game's two player scores. It sits downstream of the game logic inside the project top and directly feeds the seg/an/dp board pins. Binary scores are converted to BCD by a sequential double-dabble engine. Digits are multiplexed with a dead-time blanking gap between them, and a dot marks the serving side.

Parameters:
DIGIT_CYCLES, 65000, clk cycles each digit is driven (1 ms at 65 MHz); must exceed BLANK_CYCLES
BLANK_CYCLES, 650, leading cycles of each digit slot with all anodes off (anti-ghosting)
BLINK_CYCLES, 16250000, half-period of the change blink (SCORE_BLINK_EN only)

Ports:
clk  input  1  pixel/system clock (65 MHz domain)
rst  input  1  asynchronous, active-high reset
score_l  input  7  left player score, binary
score_r  input  7  right player score, binary
score_valid  input  1  one-cycle strobe: sample score_l/score_r
serve_side  input  1  0 = left serves, 1 = right serves
seg  output  7  segments a..g on seg[0]..seg[6], active-low
an  output  4  digit anodes, active-low; an[3] is the leftmost digit
dp  output  1  decimal point, active-low
busy  output  1  BCD conversion in progress

Behaviour:
- Reset (async, active-high): an=4'hF, seg=7'h7F, dp=1, busy=0, display registers hold 0/0, digit index=0, slot counter=0. The first digit is driven once the first slot's blanking gap has elapsed.
- Capture: on score_valid while idle, register inputs saturated to 99 (values >99 become 99); busy=1 on the next cycle.
- Conversion FSM states:
  - IDLE -> SHIFT on capture.
  - SHIFT runs 7 double-dabble iterations on both scores in parallel, one per cycle (add 3 to any nibble >=5, then shift).
  - SHIFT -> DONE after the 7th iteration.
  - DONE copies BCD to display shadow registers and returns to IDLE.
  - Latency: score_valid at cycle N gives new digits visible in the shadow registers at N+9; busy is high for cycles N+1..N+8.
- score_valid while busy: the new values are held in a 1-deep pending register (the last strobe wins). Conversion restarts from IDLE immediately after DONE. No update is ever lost except intermediate ones.
- Display is never torn: shadow registers change only in DONE, both sides at once.
- Scan:
  - The slot counter counts 0..DIGIT_CYCLES-1 and then wraps, advancing the digit index 0->1->2->3->0.
  - Index 0 = an[0] = right ones, 1 = right tens, 2 = left ones, 3 = left tens.
  - While the counter is below BLANK_CYCLES: an=4'hF, seg=7'h7F, dp=1.
  - Otherwise: the active anode is low, and seg carries the registered decode of the selected digit.
- Leading-zero blanking: a tens digit of 0 gives seg=7'h7F, with its anode still driven. Ones are always shown, so a score of 0 displays "0".
- Segment codes (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- dp=0 only while the active digit is the serving side's ones digit: index 2 if serve_side=0, index 0 if serve_side=1. serve_side is sampled live, with no latching.
- Outputs are registered; there is 1 cycle from counter state to pins.
- Reset mid-conversion aborts the FSM, clears pending and clears shadow registers to 0.

Optional Feature:
SCORE_BLINK_EN.
- Defined: when DONE changes a side's BCD value, that side's two digits blink. They are blanked (seg=7'h7F, anode still cycles) during alternate BLINK_CYCLES half-periods for 4 half-periods, starting blanked. A new change restarts that side's blink.
- Undefined: no blink logic or counters are synthesized, and the display is always steady.

Decomposition:
- Shared package disp_pkg holds:
  - the 10-entry seg code constants;
  - SEG_BLANK = 7'h7F;
  - typedef bcd2_t (struct: tens, ones nibbles);
  - the enum conv_state_t {IDLE, SHIFT, DONE}.
- One sub-module, bin2bcd_seq, holds the sequential double-dabble engine for one 7-bit value with start/done; it is instantiated twice.
- Scan, blanking, decode and dp logic stay in score_disp_7seg.

Test Plan:
- Bench parameters: DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_CYCLES=20.
- Reset release, no strobe: anodes step an=1110,1101,1011,0111 for 6 cycles each, separated by 2 cycles of an=1111 with seg=7'h7F. Index 0 and index 2 show 7'b1000000; the tens digits are blank.
- score_l=42, score_r=7, strobe at cycle N: busy is high for N+1..N+8, and the shadow registers update at N+9. After that, index 3 shows 0011001, index 2 shows 0100100, index 1 is blank and index 0 shows 1111000.
- score_r=120: saturates, and indexes 1 and 0 both show 0010000 (99).
- Strobe 10 then strobe 55 two cycles later: the display reaches 55 at most 18 cycles after the first strobe. 10 may appear transiently, but a torn mix never appears.
- serve_side=1: dp=0 only during index 0's non-blank cycles. Toggle to 0: dp moves to index 2 on the next scan.
- Under SCORE_BLINK_EN, change score_l: left digits are blank for 20 cycles, shown for 20, blank for 20, shown for 20, then steady. Right digits stay steady throughout.
